// File: rtl/serial_addsub_pkg.sv
// Shared encodings for the bit-serial adder/subtractor datapath.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder used as the serial sum/carry cell.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_dp.sv
// Bit-serial add/subtract datapath: one bit per clock, LSB first, with a
// Mealy carry flop and start/done handshake.
module serial_addsub_dp
    import serial_addsub_pkg::*;
#(
    parameter  int unsigned D_WIDTH   = 8,
    localparam int unsigned CNT_WIDTH = $clog2(D_WIDTH) + 1
) (
    input  logic                 i_clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_mode,
    input  logic                 i_cin,
    input  logic [D_WIDTH-1:0]   a_in,
    input  logic [D_WIDTH-1:0]   b_in,
    output logic [D_WIDTH-1:0]   sum,
    output logic                 o_cout,
    output logic                 o_ovf,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 p_STATE,
    output logic [CNT_WIDTH-1:0] Count_out,
    output logic [D_WIDTH-1:0]   A_o,
    output logic [D_WIDTH-1:0]   B_o
);

    state_t state_q;
    state_t state_d;
    logic   load;
    logic   shift_en;
    logic   last_bit;
    logic   s_c;
    logic   c_c;

    serial_fa_cell u_fa (
        .a    (A_o[0]),
        .b    (B_o[0]),
        .cin  (p_STATE),
        .s    (s_c),
        .cout (c_c)
    );

    // Next-state and datapath control decode.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        last_bit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (Count_out == CNT_WIDTH'(D_WIDTH - 1)) begin
                    last_bit = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_busy  <= (state_d != ST_IDLE);
            o_done  <= (state_d == ST_DONE);
        end
    end

    // Subtract is a + ~b + ~borrow_in, so both B and the carry are inverted at load.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            sum       <= '0;
            A_o       <= '0;
            B_o       <= '0;
            Count_out <= '0;
            p_STATE   <= 1'b0;
            o_cout    <= 1'b0;
            o_ovf     <= 1'b0;
        end else if (load) begin
            A_o       <= a_in;
            B_o       <= (i_mode == MODE_SUB) ? ~b_in : b_in;
            p_STATE   <= (i_mode == MODE_SUB) ? ~i_cin : i_cin;
            sum       <= '0;
            Count_out <= '0;
            o_cout    <= 1'b0;
            o_ovf     <= 1'b0;
        end else if (shift_en) begin
            sum       <= {s_c, sum[D_WIDTH-1:1]};
            A_o       <= A_o >> 1;
            B_o       <= B_o >> 1;
            p_STATE   <= c_c;
            Count_out <= Count_out + CNT_WIDTH'(1);
            if (last_bit) begin
                o_ovf  <= p_STATE ^ c_c;
                o_cout <= c_c;
            end
        end
    end

endmodule
